// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: operation codes, exception bit
// positions, register-file constants and the stage FSM encoding.
package mem_stage_pkg;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    localparam int EXC_ADEL_BIT = 12;
    localparam int EXC_ADES_BIT = 13;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) ||
               (op == EXE_SC_OP);
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear; bytes never fault.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        logic w_half;
        logic w_word;
        w_half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
        w_word = (op == EXE_LW_OP) || (op == EXE_LL_OP) || (op == EXE_SW_OP) ||
                 (op == EXE_SC_OP);
        return (w_half && lo[0]) || (w_word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Big-endian lane logic: extracts and extends load data from a bus word, and
// produces byte enables plus replicated write data for stores.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_store_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_byte_sel;
    logic [3:0]  w_half_sel;

    // Address 00 is the most significant byte of the word.
    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[31:24];
            2'b01:   w_byte = i_rdata[23:16];
            2'b10:   w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half     = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
        w_byte_sel = 4'b1000 >> i_addr_lo;
        w_half_sel = i_addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        o_load_data  = i_rdata;
        o_sel        = 4'b1111;
        o_store_data = i_store_data;
        case (i_aluop)
            EXE_LB_OP: begin
                o_load_data = {{24{w_byte[7]}}, w_byte};
                o_sel       = w_byte_sel;
            end
            EXE_LBU_OP: begin
                o_load_data = {24'h000000, w_byte};
                o_sel       = w_byte_sel;
            end
            EXE_LH_OP: begin
                o_load_data = {{16{w_half[15]}}, w_half};
                o_sel       = w_half_sel;
            end
            EXE_LHU_OP: begin
                o_load_data = {16'h0000, w_half};
                o_sel       = w_half_sel;
            end
            EXE_SB_OP: begin
                o_sel        = w_byte_sel;
                o_store_data = {4{i_store_data[7:0]}};
            end
            EXE_SH_OP: begin
                o_sel        = w_half_sel;
                o_store_data = {2{i_store_data[15:0]}};
            end
            default: begin
                o_load_data  = i_rdata;
                o_sel        = 4'b1111;
                o_store_data = i_store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a handshaked data bus for loads/stores,
// formats load results, flags address errors and tracks the LL/SC link bit.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              whilo_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       current_inst_address_i,
    input  logic              is_in_delayslot_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       excepttype_o,
    output logic [31:0]       current_inst_address_o,
    output logic              is_in_delayslot_o,
    output logic              stallreq_o,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic [DATA_W-1:0] dbus_rdata,
    input  logic              dbus_ack
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              r_llbit;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_sel;
    logic              r_bus_we;
    logic [DATA_W-1:0] r_bus_wdata;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_is_ll;
    logic              w_is_sc;
    logic              w_misaligned;
    logic              w_exc_in;
    logic              w_sc_fail;
    logic              w_go;
    logic              w_req;
    logic              w_stall;
    logic              w_from_reg;
    logic              w_capture;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [DATA_W-1:0] w_load_data;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_store_data;

    logic              w_wreg;
    logic [DATA_W-1:0] w_wdata;
    logic [31:0]       w_exc;

    assign w_is_load    = is_load_op(aluop_i);
    assign w_is_store   = is_store_op(aluop_i);
    assign w_is_mem     = w_is_load || w_is_store;
    assign w_is_ll      = (aluop_i == EXE_LL_OP);
    assign w_is_sc      = (aluop_i == EXE_SC_OP);
    assign w_misaligned = w_is_mem && is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign w_exc_in     = (excepttype_i != ZeroWord);
    assign w_sc_fail    = w_is_sc && !r_llbit;
    assign w_go         = w_is_mem && !w_misaligned && !w_exc_in && !w_sc_fail && !flush;
    assign w_bus_addr   = {mem_addr_i[ADDR_W-1:2], 2'b00};
    assign w_capture    = dbus_ack && (((r_state == S_IDLE) && w_go) ||
                                       ((r_state == S_WAIT) && !flush));

    mem_load_align u_align (
        .i_aluop      (aluop_i),
        .i_addr_lo    (mem_addr_i[1:0]),
        .i_rdata      (r_rdata),
        .i_store_data (reg2_i),
        .o_load_data  (w_load_data),
        .o_sel        (w_sel),
        .o_store_data (w_store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_llbit     <= 1'b0;
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'b0000;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_rdata <= dbus_rdata;
            end
            // Snapshot the request so a flush in WAIT can still finish it cleanly.
            if ((r_state == S_IDLE) && w_go) begin
                r_bus_addr  <= w_bus_addr;
                r_bus_sel   <= w_sel;
                r_bus_we    <= w_is_store;
                r_bus_wdata <= w_store_data;
            end
            if (flush) begin
                r_llbit <= 1'b0;
            end else if ((r_state == S_DONE) && w_is_ll) begin
                r_llbit <= 1'b1;
            end else if ((r_state == S_DONE) && w_is_sc) begin
                r_llbit <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_from_reg = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    w_next  = dbus_ack ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_req      = 1'b1;
                w_stall    = 1'b1;
                w_from_reg = 1'b1;
                if (flush) begin
                    w_next = dbus_ack ? S_IDLE : S_DRAIN;
                end else if (dbus_ack) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                w_req      = 1'b1;
                w_from_reg = 1'b1;
                if (dbus_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Memory ops only write back in DONE (or immediately for a failed SC).
    always_comb begin
        w_wreg  = wreg_i;
        w_wdata = wdata_i;
        w_exc   = excepttype_i;
        if (w_is_mem) begin
            if (w_misaligned) begin
                if (w_is_load) begin
                    w_exc[EXC_ADEL_BIT] = 1'b1;
                end else begin
                    w_exc[EXC_ADES_BIT] = 1'b1;
                end
                w_wreg = WriteDisable;
            end else if (w_exc_in) begin
                w_wreg = WriteDisable;
            end else if (r_state == S_DONE) begin
                if (w_is_load) begin
                    w_wdata = w_load_data;
                end else if (w_is_sc) begin
                    w_wdata = 32'd1;
                end
            end else if (w_sc_fail) begin
                w_wdata = ZeroWord;
            end else begin
                w_wreg = WriteDisable;
            end
        end
        if (r_state == S_DRAIN) begin
            w_wreg = WriteDisable;
        end
    end

    always_comb begin
        wd_o                   = rst ? NOPRegAddr : wd_i;
        wreg_o                 = rst ? WriteDisable : w_wreg;
        wdata_o                = rst ? '0 : w_wdata;
        whilo_o                = rst ? 1'b0 : whilo_i;
        hi_o                   = rst ? '0 : hi_i;
        lo_o                   = rst ? '0 : lo_i;
        excepttype_o           = rst ? ZeroWord : w_exc;
        current_inst_address_o = rst ? ZeroWord : current_inst_address_i;
        is_in_delayslot_o      = rst ? 1'b0 : is_in_delayslot_i;
        stallreq_o             = rst ? 1'b0 : w_stall;
        dbus_req               = 1'b0;
        dbus_we                = 1'b0;
        dbus_addr              = '0;
        dbus_sel               = 4'b0000;
        dbus_wdata             = '0;
        if (!rst && w_req) begin
            dbus_req   = 1'b1;
            dbus_we    = w_from_reg ? r_bus_we    : w_is_store;
            dbus_addr  = w_from_reg ? r_bus_addr  : w_bus_addr;
            dbus_sel   = w_from_reg ? r_bus_sel   : w_sel;
            dbus_wdata = w_from_reg ? r_bus_wdata : w_store_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed test of mem_stage: loads, stores, misalignment, LL/SC, flush and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_address_i;
    logic        is_in_delayslot_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_address_o;
    logic        is_in_delayslot_o;
    logic        stallreq_o;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    int total = 0;
    int bad   = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush                  (flush),
        .wd_i                   (wd_i),
        .wreg_i                 (wreg_i),
        .wdata_i                (wdata_i),
        .whilo_i                (whilo_i),
        .hi_i                   (hi_i),
        .lo_i                   (lo_i),
        .aluop_i                (aluop_i),
        .mem_addr_i             (mem_addr_i),
        .reg2_i                 (reg2_i),
        .excepttype_i           (excepttype_i),
        .current_inst_address_i (current_inst_address_i),
        .is_in_delayslot_i      (is_in_delayslot_i),
        .wd_o                   (wd_o),
        .wreg_o                 (wreg_o),
        .wdata_o                (wdata_o),
        .whilo_o                (whilo_o),
        .hi_o                   (hi_o),
        .lo_o                   (lo_o),
        .excepttype_o           (excepttype_o),
        .current_inst_address_o (current_inst_address_o),
        .is_in_delayslot_o      (is_in_delayslot_o),
        .stallreq_o             (stallreq_o),
        .dbus_req               (dbus_req),
        .dbus_we                (dbus_we),
        .dbus_addr              (dbus_addr),
        .dbus_sel               (dbus_sel),
        .dbus_wdata             (dbus_wdata),
        .dbus_rdata             (dbus_rdata),
        .dbus_ack               (dbus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] data);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hCAFE_0000;
        whilo_i = 1'b1; hi_i = 32'h1111_1111; lo_i = 32'h2222_2222;
        aluop_i = EXE_NOP_OP; mem_addr_i = 32'h0; reg2_i = 32'h0;
        excepttype_i = 32'h0; current_inst_address_i = 32'hBFC0_0000;
        is_in_delayslot_i = 1'b0; dbus_rdata = 32'h0; dbus_ack = 1'b0;

        tick(); tick();
        checkOutput("rst_wreg", {31'd0, wreg_o}, 32'd0);
        checkOutput("rst_wdata", wdata_o, 32'd0);
        checkOutput("rst_hi", hi_o, 32'd0);
        checkOutput("rst_stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;

        applyStimulus(8'h21, 32'h0, 32'h0);
        checkOutput("pass_wdata", wdata_o, 32'hCAFE_0000);
        checkOutput("pass_wreg", {31'd0, wreg_o}, 32'd1);
        checkOutput("pass_req", {31'd0, dbus_req}, 32'd0);

        // LW 0x100: IDLE + 3 WAIT cycles of stall, ack on the 4th cycle
        applyStimulus(EXE_LW_OP, 32'h0000_0100, 32'h0);
        checkOutput("lw_req", {31'd0, dbus_req}, 32'd1);
        checkOutput("lw_addr", dbus_addr, 32'h0000_0100);
        checkOutput("lw_sel", {28'd0, dbus_sel}, 32'hF);
        checkOutput("lw_we", {31'd0, dbus_we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
            end
            #1;
            checkOutput("lw_stall", {31'd0, stallreq_o}, 32'd1);
            tick();
        end
        dbus_ack = 1'b0; dbus_rdata = 32'h0; #1;
        checkOutput("lw_done_wdata", wdata_o, 32'hDEAD_BEEF);
        checkOutput("lw_done_wreg", {31'd0, wreg_o}, 32'd1);
        checkOutput("lw_done_stall", {31'd0, stallreq_o}, 32'd0);
        checkOutput("lw_done_req", {31'd0, dbus_req}, 32'd0);
        tick();

        dbus_ack = 1'b1; dbus_rdata = 32'h1234_56F0;
        applyStimulus(EXE_LB_OP, 32'h0000_0103, 32'h0);
        checkOutput("lb_sel", {28'd0, dbus_sel}, 32'h1);
        checkOutput("lb_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        dbus_ack = 1'b0; dbus_rdata = 32'h0; #1;
        checkOutput("lb_wdata", wdata_o, 32'hFFFF_FFF0);
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'h1234_56F0;
        applyStimulus(EXE_LBU_OP, 32'h0000_0103, 32'h0);
        tick();
        dbus_ack = 1'b0; dbus_rdata = 32'h0; #1;
        checkOutput("lbu_wdata", wdata_o, 32'h0000_00F0);
        tick();

        dbus_ack = 1'b1; dbus_rdata = 32'h8001_7F02;
        applyStimulus(EXE_LH_OP, 32'h0000_0100, 32'h0);
        tick();
        dbus_ack = 1'b0; #1;
        checkOutput("lh_wdata", wdata_o, 32'hFFFF_8001);
        tick();

        applyStimulus(EXE_SH_OP, 32'h0000_0202, 32'h0000_ABCD);
        checkOutput("sh_we", {31'd0, dbus_we}, 32'd1);
        checkOutput("sh_sel", {28'd0, dbus_sel}, 32'h3);
        checkOutput("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
        checkOutput("sh_addr", dbus_addr, 32'h0000_0200);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        tick();

        applyStimulus(EXE_SB_OP, 32'h0000_0201, 32'h0000_0055);
        checkOutput("sb_sel", {28'd0, dbus_sel}, 32'h4);
        checkOutput("sb_wdata", dbus_wdata, 32'h5555_5555);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        tick();

        applyStimulus(EXE_LW_OP, 32'h0000_0101, 32'h0);
        checkOutput("lwmis_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("lwmis_exc", excepttype_o, 32'h0000_1000);
        checkOutput("lwmis_wreg", {31'd0, wreg_o}, 32'd0);
        checkOutput("lwmis_stall", {31'd0, stallreq_o}, 32'd0);
        applyStimulus(EXE_SH_OP, 32'h0000_0201, 32'h0);
        checkOutput("shmis_exc", excepttype_o, 32'h0000_2000);
        checkOutput("shmis_req", {31'd0, dbus_req}, 32'd0);
        excepttype_i = 32'h0000_0200;
        applyStimulus(EXE_LW_OP, 32'h0000_0100, 32'h0);
        checkOutput("excin_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("excin_wreg", {31'd0, wreg_o}, 32'd0);
        checkOutput("excin_exc", excepttype_o, 32'h0000_0200);
        excepttype_i = 32'h0;

        // LL then SC: SC stores and returns 1, then link is gone
        dbus_ack = 1'b1; dbus_rdata = 32'h0000_0077;
        applyStimulus(EXE_LL_OP, 32'h0000_0300, 32'h0);
        tick();
        dbus_ack = 1'b0; #1;
        checkOutput("ll_wdata", wdata_o, 32'h0000_0077);
        tick();
        applyStimulus(EXE_SC_OP, 32'h0000_0300, 32'h0000_0099);
        checkOutput("sc_req", {31'd0, dbus_req}, 32'd1);
        checkOutput("sc_we", {31'd0, dbus_we}, 32'd1);
        checkOutput("sc_bus_wdata", dbus_wdata, 32'h0000_0099);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0; #1;
        checkOutput("sc_ok_wdata", wdata_o, 32'd1);
        checkOutput("sc_ok_wreg", {31'd0, wreg_o}, 32'd1);
        tick();
        applyStimulus(EXE_SC_OP, 32'h0000_0300, 32'h0000_0099);
        checkOutput("sc2_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("sc2_wdata", wdata_o, 32'd0);

        // LL, flush, SC
        dbus_ack = 1'b1;
        applyStimulus(EXE_LL_OP, 32'h0000_0300, 32'h0);
        tick();
        dbus_ack = 1'b0;
        tick();
        flush = 1'b1;
        applyStimulus(EXE_NOP_OP, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        applyStimulus(EXE_SC_OP, 32'h0000_0300, 32'h0000_0099);
        checkOutput("scfl_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("scfl_wdata", wdata_o, 32'd0);
        checkOutput("scfl_stall", {31'd0, stallreq_o}, 32'd0);

        // flush in the same cycle as LL completion wins
        dbus_ack = 1'b1;
        applyStimulus(EXE_LL_OP, 32'h0000_0300, 32'h0);
        tick();
        dbus_ack = 1'b0; flush = 1'b1; #1;
        tick();
        flush = 1'b0;
        applyStimulus(EXE_SC_OP, 32'h0000_0300, 32'h0000_0099);
        checkOutput("scllfl_req", {31'd0, dbus_req}, 32'd0);

        // flush during WAIT drains the bus transaction
        applyStimulus(EXE_LW_OP, 32'h0000_0400, 32'h0);
        tick();
        flush = 1'b1; #1;
        tick();
        flush = 1'b0;
        applyStimulus(EXE_NOP_OP, 32'h0, 32'h0);
        checkOutput("drain_req", {31'd0, dbus_req}, 32'd1);
        checkOutput("drain_addr", dbus_addr, 32'h0000_0400);
        checkOutput("drain_wreg", {31'd0, wreg_o}, 32'd0);
        checkOutput("drain_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        dbus_ack = 1'b1; #1;
        checkOutput("drain2_req", {31'd0, dbus_req}, 32'd1);
        checkOutput("drain2_wreg", {31'd0, wreg_o}, 32'd0);
        tick();
        dbus_ack = 1'b0; #1;
        checkOutput("drain_idle_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("drain_idle_wreg", {31'd0, wreg_o}, 32'd1);

        // reset in WAIT abandons the access and clears the link
        dbus_ack = 1'b1;
        applyStimulus(EXE_LL_OP, 32'h0000_0500, 32'h0);
        tick();
        dbus_ack = 1'b0;
        tick();
        applyStimulus(EXE_LW_OP, 32'h0000_0500, 32'h0);
        tick();
        rst = 1'b1; #1;
        tick();
        checkOutput("rstw_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("rstw_stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        applyStimulus(EXE_NOP_OP, 32'h0, 32'h0);
        checkOutput("rstw_idle_req", {31'd0, dbus_req}, 32'd0);
        applyStimulus(EXE_SC_OP, 32'h0000_0500, 32'h0000_0099);
        checkOutput("rstw_sc_req", {31'd0, dbus_req}, 32'd0);
        checkOutput("rstw_sc_wdata", wdata_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
